// File: rtl/usb_bulk_in_arb.sv
// Bulk-IN data path arbiter: routes one packet per IN transaction from the
// endpoint's source to the transfer layer, truncating at MAX_PKT and draining leftovers.
module usb_bulk_in_arb #(
  parameter int NUM_EP  = 2,
  parameter int EP_BASE = 1,
  parameter int MAX_PKT = 512
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [3:0]            blk_xfer_endpoint_i,
  input  logic                  blk_in_xfer_i,
  input  logic [NUM_EP-1:0]     src_has_data_i,
  input  logic [NUM_EP-1:0]     src_tvalid_i,
  output logic [NUM_EP-1:0]     src_tready_o,
  input  logic [NUM_EP-1:0]     src_tlast_i,
  input  logic [8*NUM_EP-1:0]   src_tdata_i,
  output logic                  bid_has_data_o,
  output logic                  bid_tvalid_o,
  input  logic                  bid_tready_i,
  output logic                  bid_tlast_o,
  output logic [7:0]            bid_tdata_o,
  output logic [3:0]            active_ep_o,
  output logic                  busy_o,
  output logic                  trunc_o,
  output logic                  abort_o
);

  localparam int SEL_W = (NUM_EP > 1) ? $clog2(NUM_EP) : 1;
  localparam int CNT_W = $clog2(MAX_PKT) + 1;

  typedef enum logic [1:0] {IDLE, XFER, DONE, DRAIN} state_t;

  state_t             state;
  logic [SEL_W-1:0]   sel;
  logic [CNT_W-1:0]   count;
  logic               in_xfer_q;

  logic [4:0]         ep_off;
  logic               hit;
  logic [SEL_W-1:0]   idx;
  logic               hit_has;
  logic               sel_has, sel_tvalid, sel_tlast;
  logic [7:0]         sel_tdata;
  logic [NUM_EP-1:0]  sel_mask;
  logic               start, beat, at_max;

  // Endpoints below EP_BASE wrap to a large offset, so one compare covers both bounds.
  assign ep_off = {1'b0, blk_xfer_endpoint_i} - 5'(EP_BASE);
  assign hit    = ep_off < 5'(NUM_EP);
  assign idx    = ep_off[SEL_W-1:0];
  assign start  = blk_in_xfer_i & ~in_xfer_q;
  assign at_max = (count == CNT_W'(MAX_PKT - 1));
  assign beat   = (state == XFER) & sel_tvalid & bid_tready_i;

  // NOTE: every variable assigned in an always_comb gets a default first, so no latch is inferred.
  always_comb begin
    hit_has    = 1'b0;
    sel_has    = 1'b0;
    sel_tvalid = 1'b0;
    sel_tlast  = 1'b0;
    sel_tdata  = 8'h00;
    sel_mask   = '0;
    for (int i = 0; i < NUM_EP; i++) begin
      if (hit && ep_off == 5'(i)) hit_has = src_has_data_i[i];
      if (sel == SEL_W'(i)) begin
        sel_has     = src_has_data_i[i];
        sel_tvalid  = src_tvalid_i[i];
        sel_tlast   = src_tlast_i[i];
        sel_tdata   = src_tdata_i[8*i +: 8];
        sel_mask[i] = 1'b1;
      end
    end
  end

  always_comb begin
    bid_has_data_o = 1'b0;
    bid_tvalid_o   = 1'b0;
    bid_tlast_o    = 1'b0;
    bid_tdata_o    = 8'h00;
    src_tready_o   = '0;
    unique case (state)
      // The IDLE lookup is combinational, so gate it with rst_n to silence it during reset.
      IDLE:  bid_has_data_o = rst_n & hit_has;
      XFER: begin
        bid_has_data_o = sel_has;
        bid_tvalid_o   = sel_tvalid;
        bid_tdata_o    = sel_tdata;
        bid_tlast_o    = sel_tlast | at_max;
        src_tready_o   = sel_mask & {NUM_EP{bid_tready_i}};
      end
      DRAIN: src_tready_o = sel_mask;
      DONE:  ;
      default: ;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      sel         <= '0;
      count       <= '0;
      in_xfer_q   <= 1'b0;
      active_ep_o <= 4'd0;
      busy_o      <= 1'b0;
      trunc_o     <= 1'b0;
      abort_o     <= 1'b0;
    end else begin
      in_xfer_q <= blk_in_xfer_i;
      trunc_o   <= 1'b0;
      abort_o   <= 1'b0;
      unique case (state)
        IDLE: begin
          if (start) begin
            busy_o <= 1'b1;
            if (hit) begin
              sel         <= idx;
              active_ep_o <= blk_xfer_endpoint_i;
              count       <= '0;
              state       <= XFER;
            end else begin
              state <= DONE;
            end
          end
        end
        XFER: begin
          if (beat) count <= count + 1'b1;
          // A tlast beat completes normally even if the host drops the transaction that cycle.
          if (beat && sel_tlast) begin
            state <= DONE;
          end else if (beat && at_max) begin
            trunc_o <= 1'b1;
            state   <= DRAIN;
          end else if (!blk_in_xfer_i) begin
            abort_o <= 1'b1;
            state   <= DRAIN;
          end
        end
        DRAIN: begin
          if (sel_tvalid && sel_tlast) state <= DONE;
        end
        DONE: begin
          if (!blk_in_xfer_i) begin
            state       <= IDLE;
            active_ep_o <= 4'd0;
            busy_o      <= 1'b0;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: doc/usb_bulk_in_arb.md
Name: usb_bulk_in_arb

Overview:
Shares the single bulk-IN data path (bid_* stream into the transfer layer) between NUM_EP on-chip packet sources, one per bulk IN endpoint. It latches the endpoint addressed by the host at the start of each IN transaction and reports that source's has-data flag. It routes exactly one packet from that source, enforces the max-packet limit, and drains abandoned packets so sources never wedge. It sits between the application FIFOs and the bid_*/blk_* ports of the USB transaction-layer top.

Parameters:
NUM_EP, 2, number of bulk IN sources (1..8)
EP_BASE, 1, endpoint number of source 0; source i serves endpoint EP_BASE+i (EP_BASE+NUM_EP-1 <= 15)
MAX_PKT, 512, max bytes per packet (64 for full-speed builds)

Ports:
clk  in  1  USB clock (60 MHz ULPI clock)
rst_n  in  1  asynchronous active-low reset
blk_xfer_endpoint_i  in  4  endpoint of current bulk transaction
blk_in_xfer_i  in  1  high for duration of a bulk IN transaction
src_has_data_i  in  NUM_EP  source i holds >=1 complete packet
src_tvalid_i  in  NUM_EP  source AXI-S valid
src_tready_o  out  NUM_EP  source AXI-S ready
src_tlast_i  in  NUM_EP  source last byte of packet
src_tdata_i  in  8*NUM_EP  source data, source i in bits [8i+7:8i]
bid_has_data_o  out  1  to transfer layer: addressed EP has a packet
bid_tvalid_o  out  1  to transfer layer: valid
bid_tready_i  in  1  from transfer layer: ready
bid_tlast_o  out  1  to transfer layer: last
bid_tdata_o  out  8  to transfer layer: data
active_ep_o  out  4  latched endpoint number (0 when idle)
busy_o  out  1  state != IDLE
trunc_o  out  1  one-cycle pulse: packet truncated at MAX_PKT
abort_o  out  1  one-cycle pulse: packet abandoned mid-transfer

Behaviour:
- Reset (rst_n low, async): state IDLE. Byte counter 0, sel 0, active_ep_o 0. All outputs 0, including src_tready_o.
- hit = blk_xfer_endpoint_i in [EP_BASE, EP_BASE+NUM_EP-1]; idx = blk_xfer_endpoint_i - EP_BASE.
- Start = rising edge of blk_in_xfer_i, registered on previous value.
- States: IDLE, XFER, DONE, DRAIN.
- IDLE: bid_has_data_o = hit & src_has_data_i[idx], combinational, zero latency. Data outputs 0.
  - Start & hit: latch sel=idx, active_ep_o=endpoint, count=0, go XFER.
  - Start & !hit: go DONE. No data routed; bid_has_data_o=0 so the transfer layer NAKs.
- XFER:
  - bid_has_data_o = src_has_data_i[sel].
  - bid_tvalid_o/tdata_o = src[sel]; src_tready_o[sel] = bid_tready_i; all other tready 0.
  - Beat = bid_tvalid_o & bid_tready_i; count increments on each beat, width clog2(MAX_PKT)+1.
  - bid_tlast_o = src_tlast_i[sel] | (count == MAX_PKT-1).
  - Beat with src tlast: go DONE.
  - Beat at count==MAX_PKT-1 without src tlast: pulse trunc_o, go DRAIN.
  - blk_in_xfer_i low before the last beat: pulse abort_o, go DRAIN. If that cycle also carries a beat with src tlast, it is a normal completion: DONE, no abort.
- DRAIN: bid_tvalid_o=0, bid_has_data_o=0, src_tready_o[sel]=1. Discards source bytes through and including tlast, then goes DONE.
- DONE: all data outputs 0, bid_has_data_o 0. When blk_in_xfer_i is low: go IDLE, active_ep_o=0. A new start cannot occur until blk_in_xfer_i has fallen.
- Endpoint changes while not IDLE are ignored; sel is held.
- Zero-length packet: a source presenting tvalid & tlast with no payload is not supported; sources signal "no data" via has_data=0.
- Only one source's tready is ever high in any cycle.

Test Plan:
- NUM_EP=2, EP_BASE=1: src1 holds 4 bytes A0..A3 with tlast; endpoint 2, blk_in_xfer 1. Required: bid_has_data_o=1 in IDLE, active_ep_o=2, bid stream A0..A3, tlast on A3, src_tready_o[0] never 1, IDLE after blk_in_xfer falls.
- Endpoint 5 (out of range), blk_in_xfer 1. Required: bid_has_data_o=0, state DONE, no tready asserted, abort_o/trunc_o 0.
- MAX_PKT=8; src0 streams 12 bytes, tlast on byte 12. Required: bid_tlast_o on byte 8, trunc_o pulse, bytes 9..12 drained with bid_tvalid_o 0, then DONE.
- blk_in_xfer drops after 3 of 10 bytes. Required: abort_o pulse, remaining 7 bytes consumed by src_tready_o[sel]=1 through tlast, IDLE.
- bid_tready_i toggled 1-0-1-0 during a 6-byte packet. Required: exactly 6 beats, byte order preserved, count==6 at tlast.
- rst_n asserted mid-XFER with no clock edge. Required: all outputs 0 immediately. After release, a new transaction works normally.
